// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared definitions for the pipelined multiply/divide
//                controller: data widths, iteration count, opcode and FSM
//                state encodings, and a small magnitude helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    // Opcode encodings as presented on eop
    typedef logic [1:0] op_t;
    localparam op_t OP_MULT  = 2'b00;
    localparam op_t OP_MULTU = 2'b01;
    localparam op_t OP_DIV   = 2'b10;
    localparam op_t OP_DIVU  = 2'b11;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_FIX  = 2'd2;

    // Magnitude of an operand for signed ops, raw value for unsigned ops.
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^31.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                             input logic              is_signed);
        mag = (is_signed && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration of an unsigned 32x32 shift-add
//                multiply or a restoring shift-subtract divide.
//                Multiply: acc = {partial product, remaining multiplier bits},
//                          operand = multiplicand.
//                Divide:   acc = {partial remainder, dividend/quotient bits},
//                          operand = divisor.
//  Ports       : acc_i     - 64-bit accumulator before the iteration
//                operand_i - multiplicand or divisor
//                is_div_i  - 1 selects divide, 0 selects multiply
//                acc_o     - 64-bit accumulator after the iteration
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Multiply: conditionally add the multiplicand into the upper half, then
    // shift the 65-bit {carry, upper, lower} right by one.
    assign w_mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                     + {1'b0, (acc_i[0] ? operand_i : {WIDTH{1'b0}})};

    // Divide: the partial remainder shifted left by one needs 33 bits. When it
    // is >= divisor the difference always fits back into 32 bits, so the
    // subtraction is done modulo 2^32.
    assign w_rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    assign w_ge     = (w_rem_sh >= {1'b0, operand_i});
    assign w_diff   = acc_i[2*WIDTH-2:WIDTH-1] - operand_i;

    always_comb begin
        acc_o = acc_i;
        if (is_div_i) begin
            acc_o = {(w_ge ? w_diff : acc_i[2*WIDTH-2:WIDTH-1]),
                     acc_i[WIDTH-2:0], w_ge};
        end else begin
            acc_o = {w_mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/pipe_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_muldiv_ctrl
//  Description : Iterative multiply/divide unit with HI/LO registers and the
//                pipeline stall interface. One iteration per clock; 33 busy
//                cycles per operation, 1 for divide by zero.
//  Ports       : clock, resetn         - clock / async active-low reset
//                estart, eop           - start request and opcode
//                ea, eb                - operands (ea is also mthi/mtlo data)
//                erd_hilo              - mfhi/mflo in EXE
//                ewr_hi, ewr_lo        - mthi/mtlo in EXE
//                busy, stall           - unit busy / hold IF-ID-EXE
//                hi, lo                - architectural HI/LO registers
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             estart,
    input  logic [1:0]       eop,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic             erd_hilo,
    input  logic             ewr_hi,
    input  logic             ewr_lo,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               state_q, state_d;
    logic [5:0]           count_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic                 is_div_q;
    logic                 neg_prod_q;
    logic                 neg_quo_q;
    logic                 neg_rem_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic                 w_is_div;
    logic                 w_is_signed;
    logic                 w_div_zero;
    logic                 w_sign_diff;
    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod_neg;
    logic [WIDTH-1:0]     w_fix_hi, w_fix_lo;

    assign w_is_div    = (eop == OP_DIV) || (eop == OP_DIVU);
    assign w_is_signed = (eop == OP_MULT) || (eop == OP_DIV);
    assign w_div_zero  = w_is_div && (eb == {WIDTH{1'b0}});
    assign w_sign_diff = w_is_signed && (ea[WIDTH-1] ^ eb[WIDTH-1]);
    assign w_mag_a     = mag(ea, w_is_signed);
    assign w_mag_b     = mag(eb, w_is_signed);

    muldiv_step u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .is_div_i  (is_div_q),
        .acc_o     (w_acc_next)
    );

    // Sign correction applied on the FIX edge. Multiply negates the full
    // 64-bit product; divide negates quotient and remainder independently.
    // The divide-by-zero path enters FIX with all sign flags clear and the
    // final {ea, all-ones} already in the accumulator.
    assign w_prod_neg = ~acc_q + 1'b1;
    always_comb begin
        w_fix_hi = acc_q[2*WIDTH-1:WIDTH];
        w_fix_lo = acc_q[WIDTH-1:0];
        if (is_div_q) begin
            if (neg_rem_q) w_fix_hi = ~acc_q[2*WIDTH-1:WIDTH] + 1'b1;
            if (neg_quo_q) w_fix_lo = ~acc_q[WIDTH-1:0] + 1'b1;
        end else if (neg_prod_q) begin
            w_fix_hi = w_prod_neg[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod_neg[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (estart) state_d = w_div_zero ? ST_FIX : ST_CALC;
            ST_CALC: if (count_q == 6'(ITER - 1)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy  = (state_q != ST_IDLE);
        stall = busy & (estart | erd_hilo | ewr_hi | ewr_lo);
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q    <= 6'd0;
            acc_q      <= {2*WIDTH{1'b0}};
            opnd_q     <= {WIDTH{1'b0}};
            is_div_q   <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= {WIDTH{1'b0}};
            lo_q       <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (estart) begin
                        count_q  <= 6'd0;
                        is_div_q <= w_is_div;
                        if (w_div_zero) begin
                            acc_q      <= {ea, {WIDTH{1'b1}}};
                            opnd_q     <= {WIDTH{1'b0}};
                            neg_prod_q <= 1'b0;
                            neg_quo_q  <= 1'b0;
                            neg_rem_q  <= 1'b0;
                        end else if (w_is_div) begin
                            acc_q      <= {{WIDTH{1'b0}}, w_mag_a};
                            opnd_q     <= w_mag_b;
                            neg_prod_q <= 1'b0;
                            neg_quo_q  <= w_sign_diff;
                            neg_rem_q  <= w_is_signed & ea[WIDTH-1];
                        end else begin
                            // Multiplier sits in the low half, shifted out LSB first
                            acc_q      <= {{WIDTH{1'b0}}, w_mag_b};
                            opnd_q     <= w_mag_a;
                            neg_prod_q <= w_sign_diff;
                            neg_quo_q  <= 1'b0;
                            neg_rem_q  <= 1'b0;
                        end
                    end else begin
                        // mthi/mtlo only take effect when no start competes
                        if (ewr_hi) hi_q <= ea;
                        if (ewr_lo) lo_q <= ea;
                    end
                end
                ST_CALC: begin
                    acc_q   <= w_acc_next;
                    count_q <= count_q + 6'd1;
                end
                ST_FIX: begin
                    hi_q <= w_fix_hi;
                    lo_q <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule : pipe_muldiv_ctrl
`default_nettype wire

// File: tb/tb_pipe_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_muldiv_ctrl
//  Description : Self-checking bench for pipe_muldiv_ctrl: a table of
//                directed operations with hand-computed HI/LO and busy
//                length, plus sequences for stall, priority and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_muldiv_ctrl;

    logic        clock = 1'b0;
    logic        resetn;
    logic        estart;
    logic [1:0]  eop;
    logic [31:0] ea, eb;
    logic        erd_hilo, ewr_hi, ewr_lo;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi, m_lo;   // bench-side model of HI/LO

    pipe_muldiv_ctrl dut (
        .clock    (clock),
        .resetn   (resetn),
        .estart   (estart),
        .eop      (eop),
        .ea       (ea),
        .eb       (eb),
        .erd_hilo (erd_hilo),
        .ewr_hi   (ewr_hi),
        .ewr_lo   (ewr_lo),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Count busy cycles from the current (first busy) cycle until busy drops.
    task automatic wait_done(input int start_n, output int n);
        n = start_n;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        estart = 1'b1; eop = v.op; ea = v.a; eb = v.b;
        step();                         // E0
        estart = 1'b0; ea = 32'hDEAD_BEEF; eb = 32'h0;
        chk({v.name, "_hold_hi"}, hi, m_hi);
        chk({v.name, "_hold_lo"}, lo, m_lo);
        wait_done(0, n);
        chk({v.name, "_busy_cycles"}, 32'(n), 32'(v.cycles));
        chk({v.name, "_hi"}, hi, v.exp_hi);
        chk({v.name, "_lo"}, lo, v.exp_lo);
        m_hi = v.exp_hi;
        m_lo = v.exp_lo;
    endtask

    initial begin
        int n;
        vt[0]  = '{"multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vt[1]  = '{"mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
        vt[2]  = '{"div_m7_2",  2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vt[3]  = '{"divu_100_7",2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
        vt[4]  = '{"div_min_m1",2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vt[5]  = '{"divu_5_0",  2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1};
        vt[6]  = '{"div_m9_0",  2'b10, 32'hFFFFFFF7, 32'h00000000, 32'hFFFFFFF7, 32'hFFFFFFFF, 1};
        vt[7]  = '{"mult_min2", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vt[8]  = '{"multu_sh",  2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 33};
        vt[9]  = '{"div_7_m2",  2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vt[10] = '{"div_m8_3",  2'b10, 32'hFFFFFFF8, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFE, 33};

        resetn = 1'b0; estart = 1'b0; eop = 2'b00; ea = 32'h0; eb = 32'h0;
        erd_hilo = 1'b0; ewr_hi = 1'b0; ewr_lo = 1'b0;
        m_hi = 32'h0; m_lo = 32'h0;

        // Reset state
        #2;
        chk("rst_busy",  {31'b0, busy},  32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        #5 resetn = 1'b1;
        step();

        // mthi / mtlo in IDLE
        ewr_hi = 1'b1; ea = 32'hCAFEBABE; #1;
        chk("mthi_stall", {31'b0, stall}, 32'h0);
        step();
        ewr_hi = 1'b0;
        chk("mthi_hi", hi, 32'hCAFEBABE);
        ewr_lo = 1'b1; ea = 32'h0BADF00D;
        step();
        ewr_lo = 1'b0;
        chk("mtlo_lo", lo, 32'h0BADF00D);
        chk("mtlo_hi_kept", hi, 32'hCAFEBABE);
        m_hi = 32'hCAFEBABE; m_lo = 32'h0BADF00D;

        // Table of operations
        for (int i = 0; i < 11; i++) run_op(vt[i]);

        // estart wins over mthi/mtlo in the same IDLE cycle
        estart = 1'b1; eop = 2'b01; ea = 32'd2; eb = 32'd3; ewr_hi = 1'b1; ewr_lo = 1'b1;
        step();
        estart = 1'b0; ewr_hi = 1'b0; ewr_lo = 1'b0;
        chk("prio_hi_not_written", hi, m_hi);
        chk("prio_lo_not_written", lo, m_lo);
        wait_done(0, n);
        chk("prio_hi", hi, 32'h0);
        chk("prio_lo", lo, 32'h6);
        m_hi = 32'h0; m_lo = 32'h6;

        // mfhi + second start raised at busy cycle 5
        estart = 1'b1; eop = 2'b01; ea = 32'h00010000; eb = 32'h00010000;
        step();
        estart = 1'b0;
        repeat (4) step();
        estart = 1'b1; eop = 2'b11; ea = 32'd100; eb = 32'd7; erd_hilo = 1'b1;
        #1;
        n = 4;
        while (busy && n < 40) begin
            chk("stall_while_busy", {31'b0, stall}, 32'h1);
            n++;
            step();
        end
        chk("stall_seq_busy_cycles", 32'(n), 32'd33);
        chk("stall_released", {31'b0, stall}, 32'h0);
        chk("stall_seq_hi", hi, 32'h00000001);
        chk("stall_seq_lo", lo, 32'h00000000);
        step();
        chk("second_start_accepted", {31'b0, busy}, 32'h1);
        estart = 1'b0; erd_hilo = 1'b0;
        wait_done(0, n);
        chk("second_busy_cycles", 32'(n), 32'd33);
        chk("second_hi", hi, 32'h00000002);
        chk("second_lo", lo, 32'h0000000E);

        // Asynchronous reset in the middle of a mult
        estart = 1'b1; eop = 2'b00; ea = 32'd5; eb = 32'd6;
        step();
        estart = 1'b0;
        repeat (9) step();
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy",  {31'b0, busy},  32'h0);
        chk("arst_stall", {31'b0, stall}, 32'h0);
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        #1 resetn = 1'b1;
        step();
        chk("post_rst_idle", {31'b0, busy}, 32'h0);
        ewr_lo = 1'b1; ea = 32'h00001234; #1;
        chk("post_rst_mtlo_stall", {31'b0, stall}, 32'h0);
        step();
        ewr_lo = 1'b0;
        chk("post_rst_lo", lo, 32'h00001234);
        chk("post_rst_hi", hi, 32'h00000000);
        chk("post_rst_busy", {31'b0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_muldiv_ctrl
`default_nettype wire
